level1: RTL and testbench

- Level-1 controller for a four-road traffic junction.
- Serves one road at a time, in fixed round-robin order 1→2→3→4→1.
- Green time for each road scales with that road's congestion sensor; empty roads are skipped.
- Drives a per-road 2-bit light code plus a one-hot "active road" vector for higher-level sequencing.

---
 rtl/level1.sv | 141 ++++++++++++++
 tb/tb_level1.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/level1.sv
// level1 : round-robin controller for a four-road junction.
//
// Only one road is served at a time, in the order 1 -> 2 -> 3 -> 4 -> 1.
// Each road's green time is set by its congestion sensor, and empty roads
// are skipped. Every green phase is followed by a yellow phase and then a
// single all-red evaluation cycle.
//
// Ports
//   T      out [3:0]  one-hot active road (bit0 = road 1 ... bit3 = road 4)
//   T1..T4 out [1:0]  per-road light: 00 RED, 01 YELLOW, 10 GREEN
//   S1..S4 in  [2:0]  thermometer congestion sensors
//                     (000 EMPTY, 001 LESS, 011 MORE, 111 FULL)
//   clock  in         rising-edge clock
//   clear  in         asynchronous active-low reset
module level1 #(
    parameter int unsigned GREEN_LESS = 2,
    parameter int unsigned GREEN_MORE = 4,
    parameter int unsigned GREEN_FULL = 6,
    parameter int unsigned YELLOW_CYC = 2
) (
    output logic [3:0] T,
    output logic [1:0] T1,
    output logic [1:0] T2,
    output logic [1:0] T3,
    output logic [1:0] T4,
    input  logic [2:0] S1,
    input  logic [2:0] S2,
    input  logic [2:0] S3,
    input  logic [2:0] S4,
    input  logic       clock,
    input  logic       clear
);

    typedef enum logic [1:0] {
        EVAL   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } state_t;

    state_t     state;
    state_t     nxt_state;
    logic [3:0] cnt;
    logic [3:0] nxt_cnt;
    logic [3:0] nxt_t;
    logic [2:0] sel;
    logic [3:0] green_len;

    // Sensor of the road currently selected by the one-hot T.
    always_comb begin
        sel = ({3{T[0]}} & S1) | ({3{T[1]}} & S2) |
              ({3{T[2]}} & S3) | ({3{T[3]}} & S4);
    end

    // Decode by highest set bit so non-thermometer codes still map sanely.
    // A result of zero means the road is empty.
    always_comb begin
        green_len = '0;
        if (sel[2])
            green_len = 4'(GREEN_FULL);
        else if (sel[1])
            green_len = 4'(GREEN_MORE);
        else if (sel[0])
            green_len = 4'(GREEN_LESS);
    end

    // Next-state logic. The counter holds the cycles remaining in the
    // current phase, so a phase ends on the edge where it reads 1.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_t     = T;
        case (state)
            EVAL: begin
                if (green_len == '0) begin
                    nxt_t = {T[2:0], T[3]};
                end else begin
                    nxt_cnt   = green_len;
                    nxt_state = GREEN;
                end
            end
            GREEN: begin
                if (cnt <= 4'd1) begin
                    nxt_cnt   = 4'(YELLOW_CYC);
                    nxt_state = YELLOW;
                end else begin
                    nxt_cnt = cnt - 4'd1;
                end
            end
            YELLOW: begin
                if (cnt <= 4'd1) begin
                    nxt_cnt   = '0;
                    nxt_t     = {T[2:0], T[3]};
                    nxt_state = EVAL;
                end else begin
                    nxt_cnt = cnt - 4'd1;
                end
            end
            default: begin
                nxt_cnt   = '0;
                nxt_t     = 4'b0001;
                nxt_state = EVAL;
            end
        endcase
    end

    // Light pattern {T4,T3,T2,T1} for a given state and active road.
    function automatic logic [7:0] light_map(input state_t st, input logic [3:0] road);
        logic [1:0] code;
        logic [7:0] res;
        case (st)
            GREEN:   code = 2'b10;
            YELLOW:  code = 2'b01;
            default: code = 2'b00;
        endcase
        res = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (road[i])
                res[2*i +: 2] = code;
        end
        return res;
    endfunction

    // Lights are registered from the next state so they line up with T.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= EVAL;
            cnt   <= '0;
            T     <= 4'b0001;
            T1    <= '0;
            T2    <= '0;
            T3    <= '0;
            T4    <= '0;
        end else begin
            state             <= nxt_state;
            cnt               <= nxt_cnt;
            T                 <= nxt_t;
            {T4, T3, T2, T1}  <= light_map(nxt_state, nxt_t);
        end
    end

endmodule

// File: tb/tb_level1.sv
module tb_level1;

    logic [3:0] T;
    logic [1:0] T1, T2, T3, T4;
    logic [2:0] S1, S2, S3, S4;
    logic       clock;
    logic       clear;
    logic [7:0] lt;

    int checks = 0;
    int errors = 0;

    level1 #(
        .GREEN_LESS(2),
        .GREEN_MORE(4),
        .GREEN_FULL(6),
        .YELLOW_CYC(2)
    ) dut (
        .T(T), .T1(T1), .T2(T2), .T3(T3), .T4(T4),
        .S1(S1), .S2(S2), .S3(S3), .S4(S4),
        .clock(clock), .clear(clear)
    );

    assign lt = {T4, T3, T2, T1};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Reset for one edge, then release away from the edge.
    // On return the DUT shows the reset EVAL cycle for road 1.
    task automatic restart;
        clear = 1'b0;
        tick();
        clear = 1'b1;
    endtask

    task automatic test_reset;
        clear = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            S1 = 3'($urandom); S2 = 3'($urandom);
            S3 = 3'($urandom); S4 = 3'($urandom);
            tick();
            checks++;
            if (T !== 4'b0001 || lt !== 8'h00) begin
                errors++;
                $display("FAIL reset cyc%0d: T=%b lights=%b required T=0001 lights=00000000", i, T, lt);
            end
        end
    endtask

    task automatic test_single_full;
        logic [7:0] e;
        S1 = 3'b111; S2 = 3'b000; S3 = 3'b000; S4 = 3'b000;
        restart();
        checks++;
        if (T !== 4'b0001 || lt !== 8'h00) begin
            errors++;
            $display("FAIL single_eval: T=%b lights=%b required 0001/00000000", T, lt);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (T !== 4'b0001 || lt !== 8'b00000010) begin
                errors++;
                $display("FAIL single_green%0d: T=%b lights=%b required 0001/00000010", i, T, lt);
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (T !== 4'b0001 || lt !== 8'b00000001) begin
                errors++;
                $display("FAIL single_yellow%0d: T=%b lights=%b required 0001/00000001", i, T, lt);
            end
        end
        for (int r = 1; r < 4; r++) begin
            tick();
            e = 8'(1) << r;
            checks++;
            if (T !== e[3:0] || lt !== 8'h00) begin
                errors++;
                $display("FAIL single_skip%0d: T=%b lights=%b required %b/00000000", r, T, lt, e[3:0]);
            end
        end
        tick();
        checks++;
        if (T !== 4'b0001 || lt !== 8'h00) begin
            errors++;
            $display("FAIL single_wrap_eval: T=%b lights=%b required 0001/00000000", T, lt);
        end
        tick();
        checks++;
        if (T !== 4'b0001 || lt !== 8'b00000010) begin
            errors++;
            $display("FAIL single_reserve: T=%b lights=%b required 0001/00000010", T, lt);
        end
    endtask

    // Mixed load: green lengths 6,4,4,4.
    task automatic test_mixed;
        int g[4];
        logic [7:0] et;
        logic [7:0] eg;
        logic [7:0] ey;
        g = '{6, 4, 4, 4};
        S1 = 3'b111; S2 = 3'b011; S3 = 3'b011; S4 = 3'b011;
        restart();
        for (int r = 0; r < 4; r++) begin
            et = 8'(1) << r;
            eg = 8'(2) << (2 * r);
            ey = 8'(1) << (2 * r);
            checks++;
            if (T !== et[3:0] || lt !== 8'h00) begin
                errors++;
                $display("FAIL mixed_eval r%0d: T=%b lights=%b required %b/00000000", r + 1, T, lt, et[3:0]);
            end
            for (int i = 0; i < g[r]; i++) begin
                tick();
                checks++;
                if (T !== et[3:0] || lt !== eg) begin
                    errors++;
                    $display("FAIL mixed_green r%0d c%0d: T=%b lights=%b required %b/%b", r + 1, i, T, lt, et[3:0], eg);
                end
            end
            for (int i = 0; i < 2; i++) begin
                tick();
                checks++;
                if (T !== et[3:0] || lt !== ey) begin
                    errors++;
                    $display("FAIL mixed_yellow r%0d c%0d: T=%b lights=%b required %b/%b", r + 1, i, T, lt, et[3:0], ey);
                end
            end
            tick();
        end
        checks++;
        if (T !== 4'b0001 || lt !== 8'h00) begin
            errors++;
            $display("FAIL mixed_wrap: T=%b lights=%b required 0001/00000000", T, lt);
        end
    endtask

    // Non-thermometer codes: 100 -> FULL(6), 010 -> MORE(4), 110 -> FULL(6).
    task automatic test_noncanonical;
        int g[4];
        logic [7:0] et;
        logic [7:0] eg;
        g = '{6, 4, 6, 2};
        S1 = 3'b100; S2 = 3'b010; S3 = 3'b110; S4 = 3'b001;
        restart();
        for (int r = 0; r < 4; r++) begin
            et = 8'(1) << r;
            eg = 8'(2) << (2 * r);
            for (int i = 0; i < g[r]; i++) begin
                tick();
                checks++;
                if (T !== et[3:0] || lt !== eg) begin
                    errors++;
                    $display("FAIL noncanon_green r%0d c%0d: T=%b lights=%b required %b/%b", r + 1, i, T, lt, et[3:0], eg);
                end
            end
            tick();
            checks++;
            if (lt !== (8'(1) << (2 * r))) begin
                errors++;
                $display("FAIL noncanon_yellow r%0d: lights=%b required %b", r + 1, lt, 8'(1) << (2 * r));
            end
            tick();
            tick();
        end
    endtask

    task automatic test_less_change;
        S1 = 3'b000; S2 = 3'b001; S3 = 3'b000; S4 = 3'b000;
        restart();
        tick();
        checks++;
        if (T !== 4'b0010 || lt !== 8'h00) begin
            errors++;
            $display("FAIL less_eval: T=%b lights=%b required 0010/00000000", T, lt);
        end
        tick();
        S2 = 3'b111;
        checks++;
        if (T !== 4'b0010 || lt !== 8'b00001000) begin
            errors++;
            $display("FAIL less_green0: T=%b lights=%b required 0010/00001000", T, lt);
        end
        tick();
        checks++;
        if (lt !== 8'b00001000) begin
            errors++;
            $display("FAIL less_green1: lights=%b required 00001000", lt);
        end
        tick();
        checks++;
        if (lt !== 8'b00000100) begin
            errors++;
            $display("FAIL less_yellow: lights=%b required 00000100 (green held 2)", lt);
        end
        // yellow 2nd, EVAL 0100, 1000, 0001, 0010
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (T !== 4'b0010 || lt !== 8'h00) begin
            errors++;
            $display("FAIL less_reeval: T=%b lights=%b required 0010/00000000", T, lt);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (T !== 4'b0010 || lt !== 8'b00001000) begin
                errors++;
                $display("FAIL less_full_green c%0d: T=%b lights=%b required 0010/00001000", i, T, lt);
            end
        end
        tick();
        checks++;
        if (lt !== 8'b00000100) begin
            errors++;
            $display("FAIL less_full_end: lights=%b required 00000100", lt);
        end
    endtask

    task automatic test_all_empty;
        logic [7:0] et;
        S1 = 3'b000; S2 = 3'b000; S3 = 3'b000; S4 = 3'b000;
        restart();
        for (int i = 0; i < 8; i++) begin
            et = 8'(1) << (i % 4);
            checks++;
            if (T !== et[3:0] || lt !== 8'h00) begin
                errors++;
                $display("FAIL empty_rot c%0d: T=%b lights=%b required %b/00000000", i, T, lt, et[3:0]);
            end
            tick();
        end
        S3 = 3'b011;
        tick();
        tick();
        checks++;
        if (T !== 4'b0100 || lt !== 8'h00) begin
            errors++;
            $display("FAIL empty_eval3: T=%b lights=%b required 0100/00000000", T, lt);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (T !== 4'b0100 || lt !== 8'b00100000) begin
                errors++;
                $display("FAIL empty_green3 c%0d: T=%b lights=%b required 0100/00100000", i, T, lt);
            end
        end
        tick();
        checks++;
        if (lt !== 8'b00010000) begin
            errors++;
            $display("FAIL empty_yellow3: lights=%b required 00010000", lt);
        end
    endtask

    task automatic test_async_reset;
        S1 = 3'b000; S2 = 3'b011; S3 = 3'b000; S4 = 3'b000;
        restart();
        tick();
        tick();
        checks++;
        if (T !== 4'b0010 || lt !== 8'b00001000) begin
            errors++;
            $display("FAIL areset_pre: T=%b lights=%b required 0010/00001000", T, lt);
        end
        #2;
        clear = 1'b0;
        #1;
        checks++;
        if (T !== 4'b0001 || lt !== 8'h00) begin
            errors++;
            $display("FAIL areset_immediate: T=%b lights=%b required 0001/00000000", T, lt);
        end
        tick();
        checks++;
        if (T !== 4'b0001 || lt !== 8'h00) begin
            errors++;
            $display("FAIL areset_hold: T=%b lights=%b required 0001/00000000", T, lt);
        end
        clear = 1'b1;
        tick();
        checks++;
        if (T !== 4'b0010 || lt !== 8'h00) begin
            errors++;
            $display("FAIL areset_restart_eval: T=%b lights=%b required 0010/00000000", T, lt);
        end
        tick();
        checks++;
        if (T !== 4'b0010 || lt !== 8'b00001000) begin
            errors++;
            $display("FAIL areset_restart_green: T=%b lights=%b required 0010/00001000", T, lt);
        end
    endtask

    initial begin
        clear = 1'b0;
        S1 = '0; S2 = '0; S3 = '0; S4 = '0;
        test_reset();
        test_single_full();
        test_mixed();
        test_noncanonical();
        test_less_change();
        test_all_empty();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
